// File: rtl/rv32i_types.sv
// Shared RV32I decode types: opcodes, immediate formats, control word and immediate extraction.
package rv32i_types;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef enum logic [1:0] {
    ALU_ADD      = 2'd0,
    ALU_FUNCT    = 2'd1,
    ALU_CMP      = 2'd2,
    ALU_PASS_IMM = 2'd3
  } alu_op_e;

  typedef struct packed {
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    logic     branch;
    logic     jump;
    logic     alu_src_imm;
    logic     alu_src_pc;
    logic     uses_rs1;
    logic     uses_rs2;
    alu_op_e  alu_op;
    imm_fmt_e imm_fmt;
  } rv32i_control_word;

  // Returns the 32-bit sign-extended immediate; callers widen to XLEN.
  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/control_rom.sv
// Opcode-indexed control word lookup; purely combinational.
module control_rom
  import rv32i_types::*;
(
  input  logic [6:0]        opcode_i,
  output rv32i_control_word ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      OPC_LUI: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.alu_src_imm = 1'b1;
        ctrl_o.alu_op      = ALU_PASS_IMM;
        ctrl_o.imm_fmt     = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.alu_src_imm = 1'b1;
        ctrl_o.alu_src_pc  = 1'b1;
        ctrl_o.imm_fmt     = IMM_U;
      end
      OPC_JAL: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.jump       = 1'b1;
        ctrl_o.alu_src_pc = 1'b1;
        ctrl_o.imm_fmt    = IMM_J;
      end
      OPC_JALR: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.jump        = 1'b1;
        ctrl_o.uses_rs1    = 1'b1;
        ctrl_o.alu_src_imm = 1'b1;
        ctrl_o.imm_fmt     = IMM_I;
      end
      OPC_BRANCH: begin
        ctrl_o.branch   = 1'b1;
        ctrl_o.uses_rs1 = 1'b1;
        ctrl_o.uses_rs2 = 1'b1;
        ctrl_o.alu_op   = ALU_CMP;
        ctrl_o.imm_fmt  = IMM_B;
      end
      OPC_LOAD: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.mem_read    = 1'b1;
        ctrl_o.uses_rs1    = 1'b1;
        ctrl_o.alu_src_imm = 1'b1;
        ctrl_o.imm_fmt     = IMM_I;
      end
      OPC_STORE: begin
        ctrl_o.mem_write   = 1'b1;
        ctrl_o.uses_rs1    = 1'b1;
        ctrl_o.uses_rs2    = 1'b1;
        ctrl_o.alu_src_imm = 1'b1;
        ctrl_o.imm_fmt     = IMM_S;
      end
      OPC_OP_IMM: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.uses_rs1    = 1'b1;
        ctrl_o.alu_src_imm = 1'b1;
        ctrl_o.alu_op      = ALU_FUNCT;
        ctrl_o.imm_fmt     = IMM_I;
      end
      OPC_OP: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.uses_rs1  = 1'b1;
        ctrl_o.uses_rs2  = 1'b1;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_bypass.sv
// NREGS x XLEN register file, x0 hardwired to zero; reads see a same-cycle writeback.
module regfile_bypass #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int RW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RW-1:0]   rs1_i,
  input  logic [RW-1:0]   rs2_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            wb_load_i,
  input  logic [RW-1:0]   wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (wb_load_i && wb_rd_i != '0) regs_d[wb_rd_i] = wb_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rs1_data_o = '0;
    if (rs1_i != '0) rs1_data_o = (wb_load_i && wb_rd_i == rs1_i) ? wb_data_i : regs_q[rs1_i];
  end

  always_comb begin
    rs2_data_o = '0;
    if (rs2_i != '0) rs2_data_o = (wb_load_i && wb_rd_i == rs2_i) ? wb_data_i : regs_q[rs2_i];
  end

endmodule

// File: rtl/id_stage_fwd.sv
// RV32I decode stage with EX/MEM/WB operand forwarding and load-use bubble insertion.
// One-cycle registered output; stall_o tells fetch to hold while stall_i or a load-use hazard is present.
module id_stage_fwd
  import rv32i_types::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [31:0]       instr_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              wb_load_i,
  input  logic [RW-1:0]     wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i,
  input  logic              ex_regwrite_i,
  input  logic              ex_is_load_i,
  input  logic [RW-1:0]     ex_rd_i,
  input  logic [XLEN-1:0]   ex_result_i,
  input  logic              mem_regwrite_i,
  input  logic [RW-1:0]     mem_rd_i,
  input  logic [XLEN-1:0]   mem_result_i,
  output logic              stall_o,
  output logic              id_valid_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [31:0]       instr_o,
  output rv32i_control_word ctrl_o,
  output logic [XLEN-1:0]   rs1_o,
  output logic [XLEN-1:0]   rs2_o,
  output logic [XLEN-1:0]   imm_o
);

  rv32i_control_word ctrl_dec;
  logic [RW-1:0]     rs1_idx, rs2_idx;
  logic [XLEN-1:0]   rs1_rf, rs2_rf, rs1_val, rs2_val;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]   imm_ext;
  logic              hazard;

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  rv32i_control_word ctrl_q, ctrl_d;
  logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;

  assign rs1_idx = RW'(instr_i[19:15]);
  assign rs2_idx = RW'(instr_i[24:20]);

  control_rom u_control_rom (
    .opcode_i (instr_i[6:0]),
    .ctrl_o   (ctrl_dec)
  );

  regfile_bypass #(.XLEN(XLEN), .NREGS(NREGS), .RW(RW)) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .rs1_i      (rs1_idx),
    .rs2_i      (rs2_idx),
    .rs1_data_o (rs1_rf),
    .rs2_data_o (rs2_rf),
    .wb_load_i  (wb_load_i),
    .wb_rd_i    (wb_rd_i),
    .wb_data_i  (wb_data_i)
  );

  // A load in EX has no data yet, so it is never a forward source; the hazard covers it.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RW-1:0]   rs,
    input logic [XLEN-1:0] rf_val,
    input logic            ex_hit_en,
    input logic [RW-1:0]   ex_rd,
    input logic [XLEN-1:0] ex_val,
    input logic            mem_hit_en,
    input logic [RW-1:0]   mem_rd,
    input logic [XLEN-1:0] mem_val
  );
    logic [XLEN-1:0] v;
    v = rf_val;
    if (rs != '0) begin
      if (ex_hit_en && ex_rd == rs)        v = ex_val;
      else if (mem_hit_en && mem_rd == rs) v = mem_val;
    end
    return v;
  endfunction

  always_comb begin
    rs1_val = fwd_sel(rs1_idx, rs1_rf, ex_regwrite_i && !ex_is_load_i, ex_rd_i, ex_result_i,
                      mem_regwrite_i, mem_rd_i, mem_result_i);
    rs2_val = fwd_sel(rs2_idx, rs2_rf, ex_regwrite_i && !ex_is_load_i, ex_rd_i, ex_result_i,
                      mem_regwrite_i, mem_rd_i, mem_result_i);
  end

  always_comb begin
    imm32   = imm_gen(instr_i, ctrl_dec.imm_fmt);
    imm_ext = XLEN'(imm32);
  end

  assign hazard = if_valid_i && ex_regwrite_i && ex_is_load_i && (ex_rd_i != '0) &&
                  ((ctrl_dec.uses_rs1 && ex_rd_i == rs1_idx) ||
                   (ctrl_dec.uses_rs2 && ex_rd_i == rs2_idx));

  assign stall_o = hazard || stall_i;

  // Flush beats stall, stall beats the load-use bubble.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ctrl_d  = ctrl_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (stall_i) begin
      valid_d = valid_q;
    end else if (hazard) begin
      valid_d = 1'b0;
    end else begin
      valid_d = if_valid_i;
      pc_d    = pc_i;
      instr_d = instr_i;
      ctrl_d  = ctrl_dec;
      rs1_d   = rs1_val;
      rs2_d   = rs2_val;
      imm_d   = imm_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      ctrl_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ctrl_q  <= ctrl_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
    end
  end

  assign id_valid_o = valid_q;
  assign pc_o       = pc_q;
  assign instr_o    = instr_q;
  assign ctrl_o     = ctrl_q;
  assign rs1_o      = rs1_q;
  assign rs2_o      = rs2_q;
  assign imm_o      = imm_q;

endmodule
